// File: rtl/accum_divider.sv
`default_nettype none
// ============================================================================
// Module   : accum_divider
// Brief    : Sequential unsigned divider; subtracts divisor once per clock
//            and counts subtractions to form the quotient.
// Revision : 1.0 - initial release
// ============================================================================
module accum_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

    state_t           r_state,     w_state_next;
    logic [WIDTH-1:0] r_quotient,  w_quotient_next;
    logic [WIDTH-1:0] r_remainder, w_remainder_next;
    logic [WIDTH-1:0] r_divisor,   w_divisor_next;
    logic             r_done,      w_done_next;
    logic             r_dbz,       w_dbz_next;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divisor   <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_divisor   <= w_divisor_next;
            r_done      <= w_done_next;
            r_dbz       <= w_dbz_next;
        end
    end

    // done is registered from the transition into DONE so it is high exactly
    // while the state register holds DONE.
    always_comb begin
        w_state_next     = r_state;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_divisor_next   = r_divisor;
        w_done_next      = 1'b0;
        w_dbz_next       = r_dbz;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_remainder_next = dividend;
                    if (divisor == '0) begin
                        w_quotient_next = C_ALL_ONES;
                        w_dbz_next      = 1'b1;
                        w_done_next     = 1'b1;
                        w_state_next    = DONE;
                    end else begin
                        w_quotient_next = '0;
                        w_divisor_next  = divisor;
                        w_dbz_next      = 1'b0;
                        w_state_next    = SUB;
                    end
                end
            end
            SUB: begin
                if (r_remainder >= r_divisor) begin
                    w_remainder_next = r_remainder - r_divisor;
                    w_quotient_next  = r_quotient + C_ONE;
                end else begin
                    w_done_next  = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ready       = (r_state == IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_accum_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_divider
// Brief    : Self-checking bench for accum_divider: directed table, corner
//            sequences and random operands against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_b;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    accum_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero returns all ones and
    // the dividend. Latency counts edges after the accepting edge.
    task automatic model(input int a, input int b, output int q, output int r,
                         output int dbz, output int lat);
        if (b == 0) begin
            q = (1 << WIDTH) - 1; r = a; dbz = 1; lat = 0;
        end else begin
            q = a / b; r = a % b; dbz = 0; lat = q + 1;
        end
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int eq, input int er, input int edbz, input int elat);
        int lat;
        @(negedge clk);
        chk({name, ".ready_before"}, 32'(ready), 32'd1);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".latency"}, 32'(lat), 32'(elat));
        chk({name, ".quotient"}, 32'(quotient), 32'(eq));
        chk({name, ".remainder"}, 32'(remainder), 32'(er));
        chk({name, ".dbz"}, 32'(div_by_zero), 32'(edbz));
        @(posedge clk); #1;
        chk({name, ".done_pulse"}, 32'(done), 32'd0);
        chk({name, ".ready_after"}, 32'(ready), 32'd1);
        chk({name, ".q_hold"}, 32'(quotient), 32'(eq));
        chk({name, ".r_hold"}, 32'(remainder), 32'(er));
        chk({name, ".dbz_hold"}, 32'(div_by_zero), 32'(edbz));
    endtask

    vec_t vt[6];

    initial begin
        int q, r, dbz, lat, n;
        logic [WIDTH-1:0] ra, rb;

        reset_b = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1 reset_b = 1'b0;
        #1 reset_b = 1'b1;
        #1;
        chk("reset.ready", 32'(ready), 32'd1);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.quotient", 32'(quotient), 32'd0);
        chk("reset.remainder", 32'(remainder), 32'd0);
        chk("reset.dbz", 32'(div_by_zero), 32'd0);

        // 13/4: intermediate remainders 9,5,1 then done
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk("seq13_4.ready_busy", 32'(ready), 32'd0);
        chk("seq13_4.r_load", 32'(remainder), 32'd13);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("seq13_4.r_step", 32'(remainder), 32'(13 - 4 * k));
            chk("seq13_4.no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        chk("seq13_4.done", 32'(done), 32'd1);
        chk("seq13_4.q", 32'(quotient), 32'd3);
        chk("seq13_4.r", 32'(remainder), 32'd1);
        chk("seq13_4.dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        chk("seq13_4.ready", 32'(ready), 32'd1);
        chk("seq13_4.done_clr", 32'(done), 32'd0);

        vt[0] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, dbz: 1'b0};
        vt[1] = '{a: 4'd3,  b: 4'd5, q: 4'd0,  r: 4'd3, dbz: 1'b0};
        vt[2] = '{a: 4'd9,  b: 4'd0, q: 4'd15, r: 4'd9, dbz: 1'b1};
        vt[3] = '{a: 4'd6,  b: 4'd2, q: 4'd3,  r: 4'd0, dbz: 1'b0};
        vt[4] = '{a: 4'd0,  b: 4'd7, q: 4'd0,  r: 4'd0, dbz: 1'b0};
        vt[5] = '{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0, dbz: 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, int'(vt[i].q), int'(vt[i].r),
                   int'(vt[i].dbz), vt[i].dbz ? 0 : int'(vt[i].q) + 1);
        end

        // 14/3 with a second start presented mid-operation: must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("busy.latency", 32'(n), 32'd5);
        chk("busy.q", 32'(quotient), 32'd4);
        chk("busy.r", 32'(remainder), 32'd2);
        @(posedge clk); #1;
        chk("busy.no_requeue", 32'(ready), 32'd1);

        // reset during 15/1 aborts with no done pulse
        @(negedge clk);
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_b = 1'b0;
        #1;
        chk("midrst.ready", 32'(ready), 32'd1);
        chk("midrst.q", 32'(quotient), 32'd0);
        chk("midrst.r", 32'(remainder), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk); #1;
        chk("midrst.no_done", 32'(done), 32'd0);
        run_op("after_rst", 4'd7, 4'd7, 1, 0, 0, 2);

        for (int i = 0; i < 30; i++) begin
            ra = WIDTH'($urandom_range(0, 15));
            rb = WIDTH'($urandom_range(0, 15));
            model(int'(ra), int'(rb), q, r, dbz, lat);
            run_op($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb, q, r, dbz, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
